// File: rtl/pkt_pkg.sv
// Shared definitions for the packet reader: FSM state encoding, default sizes and checksum helper.
// PKT_CHECKSUM_EN adds the CKSUM state to the encoding.
package pkt_pkg;

    localparam int PKT_DATA_W  = 8;
    localparam int PKT_ADDR_W  = 5;
    localparam int PKT_LEN_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND,
`ifdef PKT_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } pkt_state_t;

    // Two's complement of the running byte sum; callers truncate to their word width.
    function automatic logic [63:0] pkt_checksum(input logic [63:0] sum);
        return ~sum + 64'd1;
    endfunction

endpackage

// File: rtl/ram_pkt_reader_if.sv
// Packet reader bus: RAM read port, outgoing byte stream and status lines.
interface ram_pkt_reader_if #(
    parameter int DATA_W = pkt_pkg::PKT_DATA_W,
    parameter int ADDR_W = pkt_pkg::PKT_ADDR_W
);
    logic              package_full;
    logic [DATA_W-1:0] ram_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              busy;
    logic              pkt_done;

    modport master (
        input  package_full, ram_data, tx_ready,
        output rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, pkt_done
    );

    modport slave (
        output package_full, ram_data, tx_ready,
        input  rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, pkt_done
    );
endinterface

// File: rtl/pkt_edge_det.sv
// Registered rising-edge detector; a level already high at reset release is ignored
// until it has been seen low once.
module pkt_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q <= level;
            if (!level) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise = armed_q & level & ~prev_q;
endmodule

// File: rtl/ram_pkt_reader.sv
// Reads a PKT_LEN-word package out of the packet RAM and streams it byte by byte.
// Define PKT_CHECKSUM_EN to append a two's-complement checksum byte to each package.
module ram_pkt_reader
    import pkt_pkg::*;
#(
    parameter int DATA_W  = PKT_DATA_W,
    parameter int ADDR_W  = PKT_ADDR_W,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input logic              clk_in,
    input logic              rst,
    ram_pkt_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);

    pkt_state_t        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] hold_q;
    logic              pending_q, pending_d;
    logic              full_rise;
    logic              start;
    logic              last_word;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              pkt_done;

`ifdef PKT_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] cksum;
`endif

    pkt_edge_det u_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .level  (bus.package_full),
        .rise   (full_rise)
    );

    assign last_word = (index_q == LAST_IDX);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
            if (state_q == ST_RD_WAIT) begin
                hold_q <= bus.ram_data;
            end
        end
    end

`ifdef PKT_CHECKSUM_EN
    // Sum of every accepted data byte; restarts with each package.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (start) begin
            acc_q <= '0;
        end else if (state_q == ST_SEND && bus.tx_ready) begin
            acc_q <= acc_q + hold_q;
        end
    end

    assign cksum = DATA_W'(pkt_checksum(64'(acc_q)));
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        pending_d = pending_q;
        start     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        pkt_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_rise) begin
                    start = 1'b1;
                end
            end
            ST_RD_REQ: begin
                rd_en   = 1'b1;
                rd_addr = index_q;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = hold_q;
`ifndef PKT_CHECKSUM_EN
                tx_last  = last_word;
`endif
                if (bus.tx_ready) begin
                    if (last_word) begin
`ifdef PKT_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            ST_CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = cksum;
                tx_last  = 1'b1;
                if (bus.tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                pkt_done = 1'b1;
                // An edge landing in DONE itself is served just like a pending one.
                if (pending_q || full_rise) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d   = ST_RD_REQ;
            index_d   = '0;
            pending_d = 1'b0;
        end else if (full_rise && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end
    end

    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_last  = tx_last;
    assign bus.pkt_done = pkt_done;
    assign bus.busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ram_pkt_reader.sv
// Directed self-checking bench for ram_pkt_reader; also builds with PKT_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_ram_pkt_reader;
    localparam int PKT_LEN = 32;
`ifdef PKT_CHECKSUM_EN
    localparam int PKT_BYTES = PKT_LEN + 1;
`else
    localparam int PKT_BYTES = PKT_LEN;
`endif

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    ram_pkt_reader_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    ram_pkt_reader #(.DATA_W(8), .ADDR_W(5), .PKT_LEN(PKT_LEN)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] mem [0:PKT_LEN-1];
    logic [7:0] rx_q [$];
    logic       last_q [$];
    int         addr_q [$];
    int         rd_cnt   = 0;
    int         done_cnt = 0;
    int         total    = 0;
    int         bad      = 0;

    // RAM answers one cycle after the strobe.
    always @(posedge clk_in) begin
        if (bus.rd_en === 1'b1) begin
            bus.ram_data <= mem[bus.rd_addr];
        end
    end

    always @(negedge clk_in) begin
        if (bus.rd_en === 1'b1) begin
            addr_q.push_back(int'(bus.rd_addr));
            rd_cnt++;
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            rx_q.push_back(bus.tx_data);
            last_q.push_back(bus.tx_last);
        end
        if (bus.pkt_done === 1'b1) begin
            done_cnt++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Low for one cycle, then high: the reader sees a rising edge in the current cycle.
    task automatic apply_stimulus();
        bus.package_full = 1'b0;
        cycle();
        bus.package_full = 1'b1;
    endtask

    task automatic wait_addr(input string tag, input int addr, input int budget);
        bit found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            cycle();
            if (bus.rd_en === 1'b1 && int'(bus.rd_addr) == addr) found = 1'b1;
        end
        check_output(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_pkt_done(input string tag, input int budget);
        bit found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            cycle();
            if (bus.pkt_done === 1'b1) found = 1'b1;
        end
        check_output(tag, 32'(found), 32'd1);
    endtask

    function automatic logic [7:0] expected_byte(input int i);
        int s = 0;
        if (i < PKT_LEN) return 8'(8'h56 + i);
        for (int k = 0; k < PKT_LEN; k++) s += 8'h56 + k;
        return 8'(256 - (s % 256));
    endfunction

    task automatic check_packet(input string tag, input int rx_base, input int addr_base);
        int s = 0;
        check_output({tag, "_have_bytes"}, 32'(rx_q.size() - rx_base >= PKT_BYTES), 32'd1);
        check_output({tag, "_have_addrs"}, 32'(addr_q.size() - addr_base >= PKT_LEN), 32'd1);
        for (int i = 0; i < PKT_BYTES; i++) begin
            if (rx_base + i < rx_q.size()) begin
                check_output($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(expected_byte(i)));
                check_output($sformatf("%s_last%0d", tag, i), 32'(last_q[rx_base + i]), 32'(i == PKT_BYTES - 1));
                s += rx_q[rx_base + i];
            end
        end
        for (int i = 0; i < PKT_LEN; i++) begin
            if (addr_base + i < addr_q.size()) begin
                check_output($sformatf("%s_addr%0d", tag, i), 32'(addr_q[addr_base + i]), 32'(i));
            end
        end
`ifdef PKT_CHECKSUM_EN
        check_output({tag, "_sum_zero"}, 32'(s % 256), 32'd0);
`endif
    endtask

    initial begin
        int rx_base, addr_base, rd_base, done_base;

        for (int i = 0; i < PKT_LEN; i++) mem[i] = 8'(8'h56 + i);
        bus.package_full = 1'b0;
        bus.tx_ready     = 1'b1;

        // Reset values.
        cycle();
        cycle();
        check_output("rst_rd_en",    32'(bus.rd_en),    32'd0);
        check_output("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
        check_output("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_output("rst_tx_data",  32'(bus.tx_data),  32'd0);
        check_output("rst_tx_last",  32'(bus.tx_last),  32'd0);
        check_output("rst_busy",     32'(bus.busy),     32'd0);
        check_output("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
        rst = 1'b0;
        cycle();
        cycle();

        $display("[TB] package with tx_ready held high");
        rx_base = rx_q.size(); addr_base = addr_q.size(); rd_base = rd_cnt; done_base = done_cnt;
        apply_stimulus();
        cycle();
        check_output("s1_req_rd_en",   32'(bus.rd_en),    32'd1);
        check_output("s1_req_rd_addr", 32'(bus.rd_addr),  32'd0);
        check_output("s1_req_busy",    32'(bus.busy),     32'd1);
        check_output("s1_req_valid",   32'(bus.tx_valid), 32'd0);
        cycle();
        check_output("s1_wait_valid",  32'(bus.tx_valid), 32'd0);
        cycle();
        check_output("s1_send_valid",  32'(bus.tx_valid), 32'd1);
        check_output("s1_send_data",   32'(bus.tx_data),  32'h56);
        wait_pkt_done("s1_done_seen", 400);
        cycle();
        check_packet("s1", rx_base, addr_base);
        check_output("s1_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check_output("s1_rd_cnt",   32'(rd_cnt - rd_base),     32'(PKT_LEN));
        check_output("s1_rx_cnt",   32'(rx_q.size() - rx_base), 32'(PKT_BYTES));
        check_output("s1_idle",     32'(bus.busy),             32'd0);

        $display("[TB] stall of 5 cycles at index 10");
        rx_base = rx_q.size(); addr_base = addr_q.size(); rd_base = rd_cnt; done_base = done_cnt;
        apply_stimulus();
        wait_addr("s3_reach_10", 10, 200);
        bus.tx_ready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_output($sformatf("s3_hold_valid%0d", k), 32'(bus.tx_valid), 32'd1);
            check_output($sformatf("s3_hold_data%0d", k),  32'(bus.tx_data),  32'h60);
            check_output($sformatf("s3_hold_rd_en%0d", k), 32'(bus.rd_en),    32'd0);
        end
        bus.tx_ready = 1'b1;
        wait_pkt_done("s3_done_seen", 400);
        cycle();
        check_packet("s3", rx_base, addr_base);
        check_output("s3_rd_cnt",   32'(rd_cnt - rd_base),      32'(PKT_LEN));
        check_output("s3_done_cnt", 32'(done_cnt - done_base),  32'd1);
        check_output("s3_rx_cnt",   32'(rx_q.size() - rx_base), 32'(PKT_BYTES));

        $display("[TB] extra edges while busy");
        rx_base = rx_q.size(); addr_base = addr_q.size(); rd_base = rd_cnt; done_base = done_cnt;
        apply_stimulus();
        wait_addr("s4_reach_20", 20, 200);
        bus.package_full = 1'b0;
        cycle();
        bus.package_full = 1'b1;
        cycle();
        bus.package_full = 1'b0;
        cycle();
        bus.package_full = 1'b1;
        wait_pkt_done("s4_done_a", 400);
        cycle();
        check_output("s4_restart_rd_en", 32'(bus.rd_en),   32'd1);
        check_output("s4_restart_addr",  32'(bus.rd_addr), 32'd0);
        check_output("s4_restart_busy",  32'(bus.busy),    32'd1);
        wait_pkt_done("s4_done_b", 400);
        cycle();
        check_packet("s4a", rx_base, addr_base);
        check_packet("s4b", rx_base + PKT_BYTES, addr_base + PKT_LEN);
        for (int k = 0; k < 20; k++) cycle();
        check_output("s4_idle",     32'(bus.busy),              32'd0);
        check_output("s4_done_cnt", 32'(done_cnt - done_base),  32'd2);
        check_output("s4_rd_cnt",   32'(rd_cnt - rd_base),      32'(2 * PKT_LEN));
        check_output("s4_rx_cnt",   32'(rx_q.size() - rx_base), 32'(2 * PKT_BYTES));

        $display("[TB] reset mid-package with package_full high through release");
        done_base = done_cnt;
        apply_stimulus();
        wait_addr("s5_reach_7", 7, 200);
        cycle();
        cycle();
        check_output("s5_pre_valid", 32'(bus.tx_valid), 32'd1);
        check_output("s5_pre_data",  32'(bus.tx_data),  32'h5d);
        rst = 1'b1;
        #1;
        check_output("s5_rst_valid",   32'(bus.tx_valid), 32'd0);
        check_output("s5_rst_data",    32'(bus.tx_data),  32'd0);
        check_output("s5_rst_busy",    32'(bus.busy),     32'd0);
        check_output("s5_rst_rd_en",   32'(bus.rd_en),    32'd0);
        check_output("s5_rst_rd_addr", 32'(bus.rd_addr),  32'd0);
        check_output("s5_rst_last",    32'(bus.tx_last),  32'd0);
        check_output("s5_rst_done",    32'(bus.pkt_done), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        rd_base = rd_cnt;
        for (int k = 0; k < 10; k++) cycle();
        check_output("s6_no_read",  32'(rd_cnt - rd_base),     32'd0);
        check_output("s6_idle",     32'(bus.busy),             32'd0);
        check_output("s5_no_done",  32'(done_cnt - done_base), 32'd0);
        rx_base = rx_q.size(); addr_base = addr_q.size(); rd_base = rd_cnt;
        apply_stimulus();
        cycle();
        check_output("s5_restart_rd_en", 32'(bus.rd_en),   32'd1);
        check_output("s5_restart_addr",  32'(bus.rd_addr), 32'd0);
        wait_pkt_done("s5_done_seen", 400);
        cycle();
        check_packet("s5", rx_base, addr_base);
        check_output("s5_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check_output("s5_rd_cnt",   32'(rd_cnt - rd_base),     32'(PKT_LEN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
